// File: rtl/car_draw_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : car_draw_scheduler_if                                        |
// | Description : Control/grant bundle between stage controller, scheduler and |
// |               the bank of per-car draw FSMs.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface car_draw_scheduler_if #(
    parameter int NUM_CARS = 8
);
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    logic                start;
    logic                stop;
    logic [NUM_CARS-1:0] car_active;
    logic [NUM_CARS-1:0] car_done;
    logic [NUM_CARS-1:0] enable_draw;
    logic [IDX_W-1:0]    cur_car;
    logic                busy;
    logic                frame_done;
    logic                overrun;
    logic                timeout_err;

    modport master (
        input  start, stop, car_active, car_done,
        output enable_draw, cur_car, busy, frame_done, overrun, timeout_err
    );

    modport slave (
        output start, stop, car_active, car_done,
        input  enable_draw, cur_car, busy, frame_done, overrun, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/car_draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : car_draw_scheduler                                           |
// | Description : Per-frame round of one-at-a-time draw grants to car slots.   |
// |               Optional per-grant watchdog: define SCHED_TIMEOUT_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module car_draw_scheduler #(
    parameter int NUM_CARS       = 8,
    parameter int FRAME_TICKS    = 833333,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic            clk,
    input  wire logic            reset,
    car_draw_scheduler_if.master sched_if
);
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int CNT_W = $clog2(FRAME_TICKS);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CARS - 1);
    localparam logic [CNT_W-1:0] c_TICK_CNT = CNT_W'(FRAME_TICKS - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_WAIT_FRAME = 3'd1;
    localparam logic [2:0] c_SCAN       = 3'd2;
    localparam logic [2:0] c_GRANT      = 3'd3;
    localparam logic [2:0] c_WAIT_DONE  = 3'd4;
    localparam logic [2:0] c_FRAME_END  = 3'd5;

    if (FRAME_TICKS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("car_draw_scheduler: FRAME_TICKS and TIMEOUT_CYCLES must be >= 2");
    end

    logic [2:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;

    logic                w_tick;
    logic                w_busy;
    logic                w_slot_active;
    logic                w_slot_done;
    logic                w_tmo_hit;
    logic [NUM_CARS-1:0] w_enable_draw;

`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                tmo_err_q, tmo_err_d;

    assign w_tmo_hit = (tmo_q == c_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    assign w_tick        = (cnt_q == c_TICK_CNT);
    assign w_slot_active = sched_if.car_active[idx_q];
    assign w_slot_done   = sched_if.car_done[idx_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
`ifdef SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
`endif

        // A tick that lands mid-frame is remembered once and flagged sticky.
        if (w_tick && state_q != c_IDLE && state_q != c_WAIT_FRAME) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            c_IDLE: begin
                idx_d = '0;
                if (sched_if.start) begin
                    state_d   = c_WAIT_FRAME;
                    overrun_d = 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    tmo_err_d = 1'b0;
`endif
                end
            end
            c_WAIT_FRAME: begin
                if (w_tick || pending_q) begin
                    state_d   = c_SCAN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            c_SCAN: begin
                if (w_slot_active) begin
                    state_d = c_GRANT;
                end else if (idx_q == c_LAST_IDX) begin
                    state_d = c_FRAME_END;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            c_GRANT: begin
                state_d = c_WAIT_DONE;
`ifdef SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            c_WAIT_DONE: begin
`ifdef SCHED_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
`endif
                // A car that drops out mid-draw is treated as finished.
                if (w_slot_done || !w_slot_active || w_tmo_hit) begin
`ifdef SCHED_TIMEOUT_EN
                    if (!w_slot_done && w_slot_active) begin
                        tmo_err_d = 1'b1;
                    end
`endif
                    if (idx_q == c_LAST_IDX) begin
                        state_d = c_FRAME_END;
                    end else begin
                        state_d = c_SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            c_FRAME_END: begin
                state_d = c_WAIT_FRAME;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (sched_if.stop) begin
            state_d   = c_IDLE;
            idx_d     = '0;
            pending_d = 1'b0;
        end

        if (state_d == c_IDLE) begin
            cnt_d = '0;
        end else if (w_busy) begin
            cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        w_enable_draw = '0;
        if (state_q == c_GRANT && !sched_if.stop) begin
            w_enable_draw[idx_q] = 1'b1;
        end
        w_busy = (state_q != c_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign sched_if.timeout_err = tmo_err_q;
`else
    assign sched_if.timeout_err = 1'b0;
`endif

    assign sched_if.enable_draw = w_enable_draw;
    assign sched_if.cur_car     = idx_q;
    assign sched_if.busy        = w_busy;
    assign sched_if.frame_done  = (state_q == c_FRAME_END);
    assign sched_if.overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_car_draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_car_draw_scheduler                                        |
// | Description : Directed bench for car_draw_scheduler (4 cars, 100-cycle     |
// |               frame, 16-cycle watchdog when SCHED_TIMEOUT_EN is defined).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_car_draw_scheduler;
    localparam int NUM_CARS       = 4;
    localparam int FRAME_TICKS    = 100;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       r_start  = 1'b0;
    logic       r_stop   = 1'b0;
    logic [3:0] r_active = 4'b0000;
    logic [3:0] r_man_done  = 4'b0000;
    logic [3:0] r_resp_done = 4'b0000;
    logic       r_auto   = 1'b0;
    int         lat      = 5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         g_cyc[$];
    logic [3:0] g_val[$];
    int         fd_cyc[$];

    car_draw_scheduler_if #(.NUM_CARS(NUM_CARS)) bus ();

    assign bus.start      = r_start;
    assign bus.stop       = r_stop;
    assign bus.car_active = r_active;
    assign bus.car_done   = r_auto ? r_resp_done : r_man_done;

    car_draw_scheduler #(
        .NUM_CARS       (NUM_CARS),
        .FRAME_TICKS    (FRAME_TICKS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sched_if (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Car model: logs grants/frame ends, answers car_done `lat` cycles after a grant.
    initial begin : responder
        int pend_cnt;
        int pend_idx;
        pend_cnt = 0;
        pend_idx = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.enable_draw != 4'b0000) begin
                g_cyc.push_back(cyc);
                g_val.push_back(bus.enable_draw);
            end
            if (bus.frame_done) fd_cyc.push_back(cyc);
            r_resp_done = 4'b0000;
            if (pend_cnt != 0) begin
                pend_cnt--;
                if (pend_cnt == 0) r_resp_done[pend_idx] = 1'b1;
            end
            if (bus.enable_draw != 4'b0000) begin
                pend_cnt = lat;
                for (int i = 0; i < NUM_CARS; i++) if (bus.enable_draw[i]) pend_idx = i;
            end
        end
    end

    initial begin : stimulus
        logic [3:0] exp_g [6];
        exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

        // Reset state
        step(3);
        check("rst_busy",        bus.busy,        0);
        check("rst_enable",      bus.enable_draw, 0);
        check("rst_cur_car",     bus.cur_car,     0);
        check("rst_frame_done",  bus.frame_done,  0);
        check("rst_overrun",     bus.overrun,     0);
        check("rst_timeout_err", bus.timeout_err, 0);
        reset = 1'b0;
        step(2);
        check("idle_busy", bus.busy, 0);

        // Cars 0,1,3 active, 5-cycle draw
        r_active = 4'b1011;
        lat      = 5;
        r_auto   = 1'b1;
        g_cyc.delete(); g_val.delete(); fd_cyc.delete();
        r_start = 1'b1;
        step(1);
        r_start = 1'b0;
        check("t2_busy_after_start", bus.busy, 1);
        step(100);
        check("t2_no_grant_before_scan", bus.enable_draw, 0);
        step(1);
        check("t2_first_grant", bus.enable_draw, 4'b0001);
        step(128);
        check("t2_grant_count", g_cyc.size(), 6);
        check("t2_frame_count", fd_cyc.size(), 2);
        for (int i = 0; i < 6; i++) check($sformatf("t2_grant_%0d", i), g_val[i], exp_g[i]);
        check("t2_gap_0_1",       g_cyc[1] - g_cyc[0],   7);
        check("t2_gap_1_3",       g_cyc[2] - g_cyc[1],   8);
        check("t2_frame_len",     fd_cyc[0] - g_cyc[0],  21);
        check("t2_frame_period",  g_cyc[3] - g_cyc[0],   100);
        check("t2_done_period",   fd_cyc[1] - fd_cyc[0], 100);
        check("t2_no_overrun",    bus.overrun,           0);

        // All four active, 40-cycle draw: frame overruns
        r_stop = 1'b1;
        step(1);
        r_stop = 1'b0;
        check("t3_stop_idle", bus.busy, 0);
        r_active = 4'b1111;
        lat      = 40;
        g_cyc.delete(); g_val.delete(); fd_cyc.delete();
        r_start = 1'b1;
        step(1);
        r_start = 1'b0;
        step(299);
        check("t3_grant_count",     g_cyc.size(),          5);
        check("t3_frame_count",     fd_cyc.size(),         1);
        check("t3_gap",             g_cyc[1] - g_cyc[0],   42);
        check("t3_last_to_done",    fd_cyc[0] - g_cyc[3],  41);
        check("t3_back_to_back",    g_cyc[4] - fd_cyc[0],  3);
        check("t3_next_slot0",      g_val[4],              4'b0001);
        check("t3_overrun",         bus.overrun,           1);

        // Destroyed car mid-draw; done of another slot ignored
        r_stop = 1'b1;
        r_auto = 1'b0;
        r_man_done = 4'b0000;
        step(1);
        r_stop  = 1'b0;
        r_start = 1'b1;
        step(1);
        r_start = 1'b0;
        step(101);
        check("t4_grant0", bus.enable_draw, 4'b0001);
        step(1);
        r_man_done = 4'b0001;
        step(1);
        r_man_done = 4'b0000;
        step(1);
        check("t4_grant1", bus.enable_draw, 4'b0010);
        step(2);
        r_man_done = 4'b1000;
        step(1);
        r_man_done = 4'b0000;
        check("t4_other_done_ignored", bus.cur_car, 1);
        r_active = 4'b1101;
        step(1);
        check("t4_advance_slot2", bus.cur_car, 2);
        step(1);
        check("t4_grant2", bus.enable_draw, 4'b0100);

        // stop during GRANT
        r_stop = 1'b1;
        #1;
        check("t5_stop_masks_grant", bus.enable_draw, 0);
        step(1);
        r_stop = 1'b0;
        check("t5_idle_busy",    bus.busy,    0);
        check("t5_idle_cur_car", bus.cur_car, 0);
        r_start = 1'b1;
        step(1);
        r_start = 1'b0;
        step(100);
        check("t5_wait_full_frame", bus.enable_draw, 0);
        step(1);
        check("t5_resume_slot0", bus.enable_draw, 4'b0001);

        // Car 0 never answers
`ifdef SCHED_TIMEOUT_EN
        step(17);
        check("t6_timeout_next_slot", bus.cur_car,     1);
        check("t6_timeout_err",       bus.timeout_err, 1);
        step(3);
        check("t6_serving_slot2",     bus.cur_car,     2);
`else
        step(17);
        check("t6_still_slot0",  bus.cur_car,     0);
        check("t6_no_timeout",   bus.timeout_err, 0);
        check("t6_still_busy",   bus.busy,        1);
        step(103);
        check("t6_overrun_while_stuck", bus.overrun, 1);
        r_active = 4'b1100;
        step(3);
        check("t6_serving_slot2", bus.cur_car,     2);
        check("t6_grant2",        bus.enable_draw, 4'b0100);
`endif

        // Asynchronous reset mid-frame
        #2;
        reset = 1'b1;
        #1;
        check("t1_async_busy",        bus.busy,        0);
        check("t1_async_cur_car",     bus.cur_car,     0);
        check("t1_async_enable",      bus.enable_draw, 0);
        check("t1_async_frame_done",  bus.frame_done,  0);
        check("t1_async_overrun",     bus.overrun,     0);
        check("t1_async_timeout_err", bus.timeout_err, 0);
        step(1);
        reset = 1'b0;
        step(2);
        check("t1_idle_after_reset", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
